// File: rtl/mem_issue_queue.sv
// -----------------------------------------------------------------------------
// mem_issue_queue
//   In-order issue queue feeding the memory execution unit. Micro-ops from
//   dispatch are buffered in a circular queue, snoop a single writeback bus
//   for operands that were not ready at dispatch, are squashed by branch
//   mispredicts (left behind as bubbles) and issue one per cycle from the head
//   once both operands are ready.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_valid / o_ready        dispatch handshake (o_ready = count < DEPTH)
//   i_uop .. i_rdy2          micro-op fields, source tags/values/ready flags
//   i_wb                     wakeup bus {val, tag, data}
//   i_brkill                 one-hot mispredicted branch (0 = none)
//   i_brclear                correctly resolved branch bits to clear
//   i_flush                  discard every entry
//   o_instr                  registered packet
//                            {val, uop, brmask, rd, pc, func, imm, op2, op1}
//   o_count                  occupied entries, bubbles included
// -----------------------------------------------------------------------------
module mem_issue_queue #(
  parameter int WIDTH_Q   = 3,
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH     = 1 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [6:0]                 i_uop,
  input  logic [9:0]                 i_func,
  input  logic [WIDTH_BRM-1:0]       i_brmask,
  input  logic [WIDTH_REG-1:0]       i_rd,
  input  logic [31:0]                i_pc,
  input  logic [31:0]                i_imm,
  input  logic [WIDTH_REG-1:0]       i_rs1,
  input  logic [WIDTH_REG-1:0]       i_rs2,
  input  logic [31:0]                i_op1,
  input  logic [31:0]                i_op2,
  input  logic                       i_rdy1,
  input  logic                       i_rdy2,
  input  logic [WIDTH_REG+32:0]      i_wb,
  input  logic [WIDTH_BRM-1:0]       i_brkill,
  input  logic [WIDTH_BRM-1:0]       i_brclear,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_instr,
  output logic [WIDTH_Q:0]           o_count
);

  localparam int DEPTH = 1 << WIDTH_Q;

  // Control state
  logic [WIDTH_Q-1:0]   r_head;
  logic [WIDTH_Q-1:0]   r_tail;
  logic [WIDTH_Q:0]     r_count;
  logic [DEPTH-1:0]     r_vld;
  logic [DEPTH-1:0]     r_rdy1;
  logic [DEPTH-1:0]     r_rdy2;
  logic [WIDTH_BRM-1:0] r_brmask [DEPTH];
  logic [WIDTH-1:0]     r_instr;

  // Payload storage (not reset; qualified by the control state above)
  logic [6:0]           r_uop  [DEPTH];
  logic [9:0]           r_func [DEPTH];
  logic [WIDTH_REG-1:0] r_rd   [DEPTH];
  logic [31:0]          r_pc   [DEPTH];
  logic [31:0]          r_imm  [DEPTH];
  logic [WIDTH_REG-1:0] r_rs1  [DEPTH];
  logic [WIDTH_REG-1:0] r_rs2  [DEPTH];
  logic [31:0]          r_op1  [DEPTH];
  logic [31:0]          r_op2  [DEPTH];

  logic                 w_wb_val;
  logic [WIDTH_REG-1:0] w_wb_tag;
  logic [31:0]          w_wb_data;
  logic                 w_enq;
  logic                 w_nonempty;
  logic                 w_head_vld;
  logic                 w_head_kill;
  logic                 w_issue;
  logic                 w_bubble;
  logic                 w_pop;
  logic [WIDTH_BRM-1:0] w_in_brmask;
  logic                 w_in_kill;
  logic                 w_in_cap1;
  logic                 w_in_cap2;
  logic                 w_in_rdy1;
  logic                 w_in_rdy2;

  assign w_wb_val  = i_wb[WIDTH_REG+32];
  assign w_wb_tag  = i_wb[WIDTH_REG+31:32];
  assign w_wb_data = i_wb[31:0];

  // count never exceeds DEPTH, so its MSB alone marks the full state
  assign o_ready = ~r_count[WIDTH_Q];
  assign o_count = r_count;
  assign o_instr = r_instr;

  assign w_enq       = i_valid && o_ready && !i_flush;
  assign w_nonempty  = (r_count != '0);
  assign w_head_vld  = r_vld[r_head];
  assign w_head_kill = |(r_brmask[r_head] & i_brkill);
  assign w_issue     = w_nonempty && w_head_vld && r_rdy1[r_head] &&
                       r_rdy2[r_head] && !w_head_kill;
  assign w_bubble    = w_nonempty && !w_head_vld;
  assign w_pop       = w_issue || w_bubble;

  // Incoming micro-op: clear resolved branches, detect same-cycle kill and
  // same-cycle wakeup. Tag 0 is the hardwired zero register, always ready.
  assign w_in_brmask = i_brmask & ~i_brclear;
  assign w_in_kill   = |(i_brmask & i_brkill);
  assign w_in_cap1   = !i_rdy1 && (i_rs1 != '0) && w_wb_val && (w_wb_tag == i_rs1);
  assign w_in_cap2   = !i_rdy2 && (i_rs2 != '0) && w_wb_val && (w_wb_tag == i_rs2);
  assign w_in_rdy1   = i_rdy1 || (i_rs1 == '0) || w_in_cap1;
  assign w_in_rdy2   = i_rdy2 || (i_rs2 == '0) || w_in_cap2;

  // Queue control and issue register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      r_instr <= '0;
      for (int i = 0; i < DEPTH; i++) r_brmask[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      r_instr[WIDTH-1] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (|(r_brmask[i] & i_brkill)) r_vld[i] <= 1'b0;
        r_brmask[i] <= r_brmask[i] & ~i_brclear;
        if (w_wb_val && !r_rdy1[i] && (r_rs1[i] == w_wb_tag)) r_rdy1[i] <= 1'b1;
        if (w_wb_val && !r_rdy2[i] && (r_rs2[i] == w_wb_tag)) r_rdy2[i] <= 1'b1;
      end

      // A fresh write at tail overrides any stale per-entry update above
      if (w_enq) begin
        r_vld[r_tail]    <= !w_in_kill;
        r_brmask[r_tail] <= w_in_brmask;
        r_rdy1[r_tail]   <= w_in_rdy1;
        r_rdy2[r_tail]   <= w_in_rdy2;
        r_tail           <= r_tail + 1'b1;
      end

      if (w_pop) r_head <= r_head + 1'b1;

      if (w_enq && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_enq && w_pop) r_count <= r_count - 1'b1;

      // Issue stage boundary: packet registered toward the memory unit
      if (w_issue) begin
        r_instr <= {1'b1, r_uop[r_head], r_brmask[r_head] & ~i_brclear,
                    r_rd[r_head], r_pc[r_head], r_func[r_head], r_imm[r_head],
                    r_op2[r_head], r_op1[r_head]};
      end else begin
        r_instr[WIDTH-1] <= 1'b0;
      end
    end
  end

  // Payload write on enqueue and operand capture on wakeup
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wb_val && !r_rdy1[i] && (r_rs1[i] == w_wb_tag)) r_op1[i] <= w_wb_data;
      if (w_wb_val && !r_rdy2[i] && (r_rs2[i] == w_wb_tag)) r_op2[i] <= w_wb_data;
    end
    if (w_enq) begin
      r_uop[r_tail]  <= i_uop;
      r_func[r_tail] <= i_func;
      r_rd[r_tail]   <= i_rd;
      r_pc[r_tail]   <= i_pc;
      r_imm[r_tail]  <= i_imm;
      r_rs1[r_tail]  <= i_rs1;
      r_rs2[r_tail]  <= i_rs2;
      r_op1[r_tail]  <= w_in_cap1 ? w_wb_data : i_op1;
      r_op2[r_tail]  <= w_in_cap2 ? w_wb_data : i_op2;
    end
  end

endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order issue queue for the load/store pipe. It buffers memory micro-ops from dispatch and snoops one writeback/bypass bus to capture operands that are not yet ready. It squashes entries on branch mispredict and issues at most one fully-ready micro-op per cycle to the memory execution unit, which registers the packet on its input. It is the producing end of the memory unit's packed instruction interface.

## Interface
- WIDTH_Q, 3: log2 of queue depth (DEPTH = 2^WIDTH_Q entries).
- WIDTH_BRM, 4: branch-mask width.
- WIDTH_REG, 5: physical register tag width.
- WIDTH, 1+7+WIDTH_BRM+WIDTH_REG+10+4*32: issued packet width.

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  dispatch offers a micro-op this cycle.
- o_ready  out  1  queue accepts. Equals (count < DEPTH), from registered count.
- i_uop  in  7  opcode.
- i_func  in  10  size code (0 byte, 1 half, 2 word).
- i_brmask  in  WIDTH_BRM  branches this micro-op depends on.
- i_rd  in  WIDTH_REG  destination tag.
- i_pc  in  32  PC.
- i_imm  in  32  immediate.
- i_rs1  in  WIDTH_REG  source-1 tag.
- i_rs2  in  WIDTH_REG  source-2 tag.
- i_op1  in  32  source-1 value.
- i_op2  in  32  source-2 value.
- i_rdy1  in  1  i_op1 already valid.
- i_rdy2  in  1  i_op2 already valid.
- i_wb  in  1+WIDTH_REG+32  wakeup bus {val, tag, data}.
- i_brkill  in  WIDTH_BRM  one-hot mispredicted branch; 0 means none.
- i_brclear  in  WIDTH_BRM  resolved-correct branch bits to clear.
- i_flush  in  1  discard all entries.
- o_instr  out  WIDTH  registered packet {val, uop, brmask, rd, pc, func, imm, op2, op1}.
- o_count  out  WIDTH_Q+1  occupied entries, including bubbles.

## Operation
- Storage is a circular buffer with head pointer, tail pointer and count. Each entry holds: valid, fields, op1/op2, rdy1/rdy2, and rs1/rs2 tags.
- Enqueue occurs when i_valid && o_ready. The entry is written at tail and tail advances (wraps mod DEPTH).
  - A source is marked ready if its rdyN is set, its tag is 0, or i_wb.val && i_wb.tag == rsN in the same cycle. In the wakeup case, i_wb.data is stored.
- Wakeup: every stored entry with rdyN=0 and rsN == i_wb.tag (with i_wb.val=1) captures the data and sets rdyN.
- Issue: if the head entry is valid && rdy1 && rdy2 && (brmask & i_brkill)==0:
  - o_instr is loaded with val=1, brmask = (entry brmask & ~i_brclear), and the remaining fields.
  - Head is popped.
- Bubble pop: if the head entry is invalid, it is popped with o_instr.val=0. This costs one cycle per bubble.
- Otherwise o_instr.val=0 and the other o_instr fields hold their last values.
- Issue is strictly in order. A non-ready head blocks all younger entries.
- Branch kill: every entry with (brmask & i_brkill)!=0 is invalidated. Such entries remain as bubbles until popped. This includes an entry enqueued in the same cycle whose i_brmask matches.
- Branch clear: all stored brmasks, and the incoming i_brmask, are ANDed with ~i_brclear.
- Flush: on the next edge head=tail=count=0 and o_instr.val=0. The enqueue in that cycle is dropped. Flush has priority over everything.
- Count update: count += enq − pop. Enqueue and pop in the same cycle leave count unchanged.

## Timing
- Reset values: head=tail=count=0; all entry valid bits=0; o_instr=0 (val=0); o_ready=1; o_count=0.
- Minimum latency: an operand-ready micro-op enqueued at edge N appears on o_instr after edge N+1.
- Wakeup at edge N makes the head issuable; o_instr.val=1 after edge N+1.
- Full: with count=DEPTH, o_ready=0 even if a pop occurs this cycle. Enqueue resumes the cycle after count drops.
- Simultaneous kill and issue of the head: issue is suppressed and the head becomes a bubble.
- Reset asserted mid-operation clears all state immediately, independent of the clock.

## Test plan
- Reset, then enqueue lw with uop=0x03, rs1=0 and rdy2=1, at edge 1 -> o_instr.val=1 after edge 2 with op1+imm fields unchanged; o_count returns to 0.
- Enqueue sw with rdy1=0, rs1=7; i_wb={1,7,0x100} two cycles later -> op1=0x100 issued exactly one cycle after the wakeup edge.
- Fill 8 entries with the head not ready -> o_ready=0 and o_count=8; wake the head -> entries drain one per cycle in enqueue order; o_ready=1 the cycle after the first pop.
- Entries with brmask 0001, 0010, 0011; i_brkill=0010 -> only the first issues; the two bubbles each take one cycle and produce no o_instr.val.
- i_brclear=0001 while an entry with brmask 0001 is held -> it issues with brmask 0000.
- i_flush with 5 entries and a concurrent i_valid -> o_count=0 on the next cycle, no issue follows; the next enqueue issues normally.
